// File: rtl/tape_mem_resp.sv
// rtl/tape_mem_resp.sv - tape-cell memory responder: zero-fill after reset, 2-cycle read pipeline, write-back port.
// Reads snapshot the cell at acceptance (write-first on a same-cycle same-index write).
module tape_mem_resp #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic [15:0] mem_addr,
    output logic [15:0] mem_data,
    output logic        mem_valid,
    input  logic        wr_en,
    input  logic [15:0] wr_addr,
    input  logic [15:0] wr_data,
    output logic        ready,
    output logic        addr_err
);

    localparam logic [0:0]    S_CLEAR  = 1'b0;
    localparam logic [0:0]    S_RUN    = 1'b1;
    localparam logic [AW-1:0] CLR_LAST = AW'(DEPTH - 1);

    logic [0:0]    r_state;
    logic [AW-1:0] r_clr_cnt;
    logic [15:0]   r_mem [DEPTH];
    logic          r_s1_valid;
    logic [15:0]   r_s1_data;
    logic          r_s2_valid;
    logic [15:0]   r_s2_data;
    logic          r_addr_err;

    logic          w_run;
    logic          w_rd_acc;
    logic          w_wr_acc;
    logic [AW-1:0] w_rd_idx;
    logic [AW-1:0] w_wr_idx;
    logic          w_rd_oor;
    logic          w_wr_oor;
    logic [15:0]   w_rd_word;

    assign w_run    = (r_state == S_RUN);
    assign w_rd_acc = w_run & mem_en;
    assign w_wr_acc = w_run & wr_en;
    assign w_rd_idx = mem_addr[AW-1:0];
    assign w_wr_idx = wr_addr[AW-1:0];
    // Any address bit above the index makes the access out of range; it still wraps.
    assign w_rd_oor = ((mem_addr >> AW) != 16'd0);
    assign w_wr_oor = ((wr_addr >> AW) != 16'd0);
    assign w_rd_word = (w_wr_acc && (w_wr_idx == w_rd_idx)) ? wr_data : r_mem[w_rd_idx];

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!w_run) begin
                r_mem[r_clr_cnt] <= 16'd0;
            end else if (wr_en) begin
                r_mem[w_wr_idx] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_CLEAR;
            r_clr_cnt  <= '0;
            r_s1_valid <= 1'b0;
            r_s1_data  <= 16'd0;
            r_s2_valid <= 1'b0;
            r_s2_data  <= 16'd0;
            r_addr_err <= 1'b0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + AW'(1);
                    if (r_clr_cnt == CLR_LAST) begin
                        r_state <= S_RUN;
                    end
                end
                default: r_state <= S_RUN;
            endcase

            r_s1_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_s1_data <= w_rd_word;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data <= r_s1_data;
            end

            if ((w_rd_acc && w_rd_oor) || (w_wr_acc && w_wr_oor)) begin
                r_addr_err <= 1'b1;
            end
        end
    end

    assign mem_data  = r_s2_data;
    assign mem_valid = r_s2_valid;
    assign ready     = w_run;
    assign addr_err  = r_addr_err;

endmodule
